hsv_seq_ctrl: RTL and testbench
===============================

Name: hsv_seq_ctrl

Overview:
- Sequenced, handshaked RGB-to-HSV pixel converter for the vision path.
- Accepts one 8-bit RGB pixel, then time-shares a single iterative restoring divider between two divisions: saturation first, hue fraction second.
- Returns H/S/V through a valid/ready output port.
- Sits between the camera pixel stream and the colour-threshold logic; trades throughput for one small divider.

Parameters:
- FAST_GRAY, 1, when 1 a pixel with delta==0 bypasses both divisions; when 0 every pixel takes the full divider path.
- SAT_SCALE, 255, saturation full-scale numerator multiplier (8-bit, nonzero).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  pixel present
- in_ready  out  1  block can accept a pixel
- red  in  8  red component
- green  in  8  green component
- blue  in  8  blue component
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- hue  out  9  hue, 0..359 degrees
- saturation  out  8  0..SAT_SCALE
- value  out  8  max(R,G,B)
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge: state=IDLE; out_valid=0; hue, saturation, value=0; divider registers cleared. in_ready=1 and busy=0 in the cycle after reset release.
- Reset mid-operation aborts the pixel with no output.
- States:
  - IDLE: in_ready=1.
  - DIV_S
  - DIV_H
  - FIX
  - OUT
- Accept (edge k, in_valid & in_ready):
  - Register R, G, B.
  - max/min use priority red > green > blue on ties.
  - delta = max - min.
  - value = max.
- Divider: 16-bit dividend / 8-bit divisor, restoring, one quotient bit per cycle, 16 cycles per division.
- DIV_S (cycles k+1..k+16):
  - saturation = floor(SAT_SCALE*delta / max).
  - max==0 implies delta==0, so this case never reaches the divider.
- DIV_H (cycles k+17..k+32):
  - max channel is red: num = G - B.
  - max channel is green: num = B - R.
  - max channel is blue: num = R - G.
  - q = floor(60*|num| / delta), so 0 <= q <= 60.
- FIX (cycle k+33):
  - base = 0 / 120 / 240 for red / green / blue.
  - hue = base + q if num >= 0, else base - q, taken mod 360: 360 maps to 0, and a negative result adds 360.
- OUT (edge k+34 onward):
  - out_valid=1; hue, saturation and value stable.
  - Hold until out_ready=1. At that edge go to IDLE and drop out_valid.
  - in_ready returns the next cycle; there is no accept in the same cycle as output handoff.
- Gray path (FAST_GRAY=1, delta==0):
  - IDLE -> FIX -> OUT; hue=0, saturation=0.
  - out_valid at edge k+2.
- Gray path (FAST_GRAY=0, delta==0): full sequence; the divider is forced to return 0 when the divisor is 0. No X, no divide-by-zero.
- Inputs changing while busy are ignored.
- in_valid asserted while in_ready=0 is not consumed.
- Throughput: 1 pixel per 35 cycles on the slow path, 3 cycles on the gray path, both with out_ready held high.

Test Plan:
- (255,0,0) accepted, out_ready=1 -> out_valid exactly 34 cycles after accept; H=0, S=255, V=255.
- (0,255,0) -> H=120, S=255, V=255. (0,0,255) -> H=240, S=255, V=255.
- (255,0,128) -> q=floor(7680/255)=30, negative num -> H=330, S=255, V=255. (255,0,1) -> q=0, H=0 (wrap).
- Tie (200,200,50) -> red wins, delta=150, H=60, S=191, V=200.
- Gray (128,128,128) with FAST_GRAY=1 -> H=0, S=0, V=128, out_valid 2 cycles after accept. Black (0,0,0) -> all zero, no X. Repeat both with FAST_GRAY=0 -> same values at 34 cycles.
- Back-pressure: hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout. Then pulse rst_n=0 during DIV_H of the next pixel -> IDLE, out_valid=0, outputs 0, no spurious result.

Source files
------------

// File: rtl/hsv_seq_ctrl.sv
// ============================================================================
// hsv_seq_ctrl
// ----------------------------------------------------------------------------
// Converts one 8-bit RGB pixel at a time into hue / saturation / value.
// The block shares one iterative restoring divider between two divisions.
// The saturation division runs first, followed by the hue-fraction division.
// This keeps the block small at the cost of throughput, which suits the slow
// camera-to-threshold path that it sits on.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    a pixel is present on red/green/blue
//   in_ready    the block can accept a pixel (only while idle)
//   red         red component
//   green       green component
//   blue        blue component
//   out_valid   hue/saturation/value hold a finished result
//   out_ready   the consumer takes the result on this edge
//   hue         hue in degrees, 0..359
//   saturation  saturation, 0..SAT_SCALE
//   value       max(R,G,B)
//   busy        a pixel is in flight (state is not IDLE)
//
// Parameters
//   FAST_GRAY   when 1, a pixel with delta==0 skips both divisions
//   SAT_SCALE   numerator multiplier for saturation full scale
// ============================================================================
module hsv_seq_ctrl #(
    parameter bit         FAST_GRAY = 1'b1,
    parameter logic [7:0] SAT_SCALE = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] hue,
    output logic [7:0] saturation,
    output logic [7:0] value,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIV_S = 3'd1,
        DIV_H = 3'd2,
        FIX   = 3'd3,
        OUT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2
    } chan_t;

    state_t state;
    state_t state_next;

    // Analysis of the incoming pixel. These values are only used on the accept edge.
    chan_t       px_max_ch;
    logic [7:0]  px_max;
    logic [7:0]  px_min;
    logic [7:0]  px_delta;
    logic [8:0]  px_num;
    logic        px_num_neg;
    logic [7:0]  px_num_abs;
    logic        px_gray;
    logic [15:0] sat_dividend;
    logic        accept;

    // Per-pixel state that is kept for the hue division and the final fix-up step.
    chan_t       max_ch_r;
    logic        num_neg_r;
    logic [7:0]  num_abs_r;
    logic [7:0]  delta_r;
    logic [7:0]  hue_q_r;
    logic [15:0] hue_dividend;

    // Registers and single-step logic of the shared restoring divider.
    logic [3:0]  div_cnt;
    logic [7:0]  div_rem;
    logic [15:0] div_quo;
    logic [7:0]  div_den;
    logic [8:0]  div_trial;
    logic        div_fits;
    logic [7:0]  div_rem_next;
    logic [15:0] div_quo_next;
    logic [7:0]  div_result;
    logic        div_last;

    // Logic for the hue fix-up step.
    logic [8:0]  hue_base;
    logic [8:0]  hue_q_ext;
    logic [8:0]  hue_sum;
    logic [8:0]  hue_fixed;

    assign accept = in_valid && (state == IDLE);

    // Find the maximum channel with red > green > blue priority on ties.
    // The hue numerator depends on which channel wins. Only its magnitude
    // goes through the divider. Its sign is applied in FIX.
    always_comb begin
        px_max_ch = CH_RED;
        px_max    = red;
        if ((red >= green) && (red >= blue)) begin
            px_max_ch = CH_RED;
            px_max    = red;
        end else if (green >= blue) begin
            px_max_ch = CH_GREEN;
            px_max    = green;
        end else begin
            px_max_ch = CH_BLUE;
            px_max    = blue;
        end

        px_min = red;
        if (green < px_min) begin
            px_min = green;
        end
        if (blue < px_min) begin
            px_min = blue;
        end

        px_delta = px_max - px_min;
        px_gray  = (px_delta == 8'd0);

        case (px_max_ch)
            CH_RED:   px_num = {1'b0, green} - {1'b0, blue};
            CH_GREEN: px_num = {1'b0, blue}  - {1'b0, red};
            default:  px_num = {1'b0, red}   - {1'b0, green};
        endcase

        // The difference of two 8-bit values lies in -255..255. Negating
        // the low byte modulo 256 gives the exact magnitude for every such value.
        px_num_neg = px_num[8];
        px_num_abs = px_num_neg ? (8'd0 - px_num[7:0]) : px_num[7:0];
    end

    // Both dividends fit in 16 bits: 255*255 = 65025 and 60*255 = 15300.
    assign sat_dividend = {8'd0, SAT_SCALE} * {8'd0, px_delta};
    assign hue_dividend = 16'd60 * {8'd0, num_abs_r};

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, then subtract the divisor if it fits.
    // When it fits, the true difference is below the divisor. An 8-bit
    // modular subtraction is therefore exact.
    // A divisor of zero would produce an all-ones quotient, so the result
    // is forced to zero in that case.
    always_comb begin
        div_trial    = {div_rem, div_quo[15]};
        div_fits     = (div_trial >= {1'b0, div_den});
        div_rem_next = div_fits ? (div_trial[7:0] - div_den) : div_trial[7:0];
        div_quo_next = {div_quo[14:0], div_fits};
        div_result   = (div_den == 8'd0) ? 8'd0 : div_quo_next[7:0];
        div_last     = (div_cnt == 4'd15);
    end

    // Hue fix-up: add or subtract the quotient from the sector base, then wrap into 0..359.
    // Every intermediate value stays below 512, so nine bits are enough:
    // - 240 + 255 at most on the add path.
    // - base + (360 - q) on the negative path, which is only taken when q > base.
    always_comb begin
        case (max_ch_r)
            CH_RED:   hue_base = 9'd0;
            CH_GREEN: hue_base = 9'd120;
            default:  hue_base = 9'd240;
        endcase
        hue_q_ext = {1'b0, hue_q_r};
        hue_sum   = 9'd0;
        hue_fixed = 9'd0;
        if (num_neg_r) begin
            if (hue_q_ext > hue_base) begin
                hue_fixed = hue_base + (9'd360 - hue_q_ext);
            end else begin
                hue_fixed = hue_base - hue_q_ext;
            end
        end else begin
            hue_sum = hue_base + hue_q_ext;
            if (hue_sum >= 9'd360) begin
                hue_fixed = hue_sum - 9'd360;
            end else begin
                hue_fixed = hue_sum;
            end
        end
    end

    // State register. A reset at any point drops the pixel in flight without producing a result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A gray pixel on the fast path goes straight to FIX.
    // Each divide state lasts exactly 16 cycles, counted by div_cnt.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (FAST_GRAY && px_gray) ? FIX : DIV_S;
                end
            end
            DIV_S: begin
                if (div_last) begin
                    state_next = DIV_H;
                end
            end
            DIV_H: begin
                if (div_last) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs depend only on the state. This rules out an accept
    // in the same cycle as the output handoff.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    // Datapath. The edge that ends the saturation division stores its quotient.
    // The same edge reloads the divider for the hue division, so no cycle is lost between the two divisions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hue        <= 9'd0;
            saturation <= 8'd0;
            value      <= 8'd0;
            max_ch_r   <= CH_RED;
            num_neg_r  <= 1'b0;
            num_abs_r  <= 8'd0;
            delta_r    <= 8'd0;
            hue_q_r    <= 8'd0;
            div_cnt    <= 4'd0;
            div_rem    <= 8'd0;
            div_quo    <= 16'd0;
            div_den    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        value     <= px_max;
                        delta_r   <= px_delta;
                        max_ch_r  <= px_max_ch;
                        num_neg_r <= px_num_neg;
                        num_abs_r <= px_num_abs;
                        div_cnt   <= 4'd0;
                        div_rem   <= 8'd0;
                        div_quo   <= sat_dividend;
                        div_den   <= px_max;
                        // A gray pixel on the fast path skips the divider. Its
                        // results are known here: the red channel wins the tie,
                        // so the hue is 0 and the saturation is 0.
                        if (FAST_GRAY && px_gray) begin
                            saturation <= 8'd0;
                            hue_q_r    <= 8'd0;
                        end
                    end
                end
                DIV_S: begin
                    div_cnt <= div_cnt + 4'd1;
                    if (div_last) begin
                        saturation <= div_result;
                        div_rem    <= 8'd0;
                        div_quo    <= hue_dividend;
                        div_den    <= delta_r;
                    end else begin
                        div_rem <= div_rem_next;
                        div_quo <= div_quo_next;
                    end
                end
                DIV_H: begin
                    div_cnt <= div_cnt + 4'd1;
                    div_rem <= div_rem_next;
                    div_quo <= div_quo_next;
                    if (div_last) begin
                        hue_q_r <= div_result;
                    end
                end
                FIX: begin
                    hue <= hue_fixed;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_seq_ctrl.sv
// ============================================================================
// tb_hsv_seq_ctrl
// ----------------------------------------------------------------------------
// Drives two instances of hsv_seq_ctrl: one with the gray fast path and one
// without it. The two instances share the pixel bus. An expected result is
// queued whenever a pixel is offered. The monitor compares the queued result
// on every output handoff.
// ============================================================================
module tb_hsv_seq_ctrl;

    localparam int SAT_FULL = 255;

    typedef struct {
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } res_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
        int         lat_fast;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] red, green, blue;
    logic       in_valid, out_ready, use_slow;

    logic       f_in_valid, f_in_ready, f_out_valid, f_busy;
    logic [8:0] f_hue;
    logic [7:0] f_sat, f_val;
    logic       s_in_valid, s_in_ready, s_out_valid, s_busy;
    logic [8:0] s_hue;
    logic [7:0] s_sat, s_val;

    logic       m_in_ready, m_out_valid, m_busy;
    logic [8:0] m_hue;
    logic [7:0] m_sat, m_val;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];
    res_t mon_e;
    vec_t tbl[8];

    always #5 clk = ~clk;

    assign f_in_valid  = in_valid & ~use_slow;
    assign s_in_valid  = in_valid &  use_slow;
    assign m_in_ready  = use_slow ? s_in_ready  : f_in_ready;
    assign m_out_valid = use_slow ? s_out_valid : f_out_valid;
    assign m_busy      = use_slow ? s_busy      : f_busy;
    assign m_hue       = use_slow ? s_hue       : f_hue;
    assign m_sat       = use_slow ? s_sat       : f_sat;
    assign m_val       = use_slow ? s_val       : f_val;

    hsv_seq_ctrl #(.FAST_GRAY(1'b1), .SAT_SCALE(8'd255)) dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (f_in_valid),
        .in_ready   (f_in_ready),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .out_valid  (f_out_valid),
        .out_ready  (out_ready),
        .hue        (f_hue),
        .saturation (f_sat),
        .value      (f_val),
        .busy       (f_busy)
    );

    hsv_seq_ctrl #(.FAST_GRAY(1'b0), .SAT_SCALE(8'd255)) dut_slow (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .hue        (s_hue),
        .saturation (s_sat),
        .value      (s_val),
        .busy       (s_busy)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference conversion written directly from the colour-space definition.
    function automatic res_t model(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int   ri, gi, bi, mx, mn, d, num, q, h, base;
        res_t o;
        ri = int'(r); gi = int'(g); bi = int'(b);
        if (ri >= gi && ri >= bi) begin
            mx = ri; num = gi - bi; base = 0;
        end else if (gi >= bi) begin
            mx = gi; num = bi - ri; base = 120;
        end else begin
            mx = bi; num = ri - gi; base = 240;
        end
        mn = ri;
        if (gi < mn) mn = gi;
        if (bi < mn) mn = bi;
        d = mx - mn;
        o.v = 8'(mx);
        o.s = (mx == 0) ? 8'd0 : 8'((SAT_FULL * d) / mx);
        if (d == 0) begin
            h = 0;
        end else begin
            q = (60 * ((num < 0) ? -num : num)) / d;
            h = (num < 0) ? base - q : base + q;
            if (h < 0) h = h + 360;
            if (h >= 360) h = h - 360;
        end
        o.h = 9'(h);
        return o;
    endfunction

    // The monitor checks every handoff (out_valid and out_ready both high).
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_output: got hue %0d sat %0d val %0d, expected no output",
                         m_hue, m_sat, m_val);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("hue", 32'(m_hue), 32'(mon_e.h));
                check_output("saturation", 32'(m_sat), 32'(mon_e.s));
                check_output("value", 32'(m_val), 32'(mon_e.v));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && m_in_ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check_output("idle_wait in_ready", 32'(m_in_ready), 32'd1);
    endtask

    // Offers a pixel, measures the cycles from the accept edge until out_valid is first seen, then confirms the handoff.
    task automatic apply_stimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                  input res_t e, input int exp_lat, input string name);
        int lat;
        wait_idle();
        red = r; green = g; blue = b; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        red = 8'($urandom_range(0, 255));
        green = 8'($urandom_range(0, 255));
        blue = 8'($urandom_range(0, 255));
        lat = 1;
        while (lat <= 100) begin
            @(negedge clk);
            if (m_out_valid === 1'b1) break;
            lat++;
        end
        check_output({name, " latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        check_output({name, " handoff"}, {30'd0, m_out_valid, m_in_ready}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        res_t e;
        int   lat;
        int   spurious;
        logic [7:0] r, g, b;

        tbl[0] = '{r:8'd255, g:8'd0,   b:8'd0,   h:9'd0,   s:8'd255, v:8'd255, lat_fast:34};
        tbl[1] = '{r:8'd0,   g:8'd255, b:8'd0,   h:9'd120, s:8'd255, v:8'd255, lat_fast:34};
        tbl[2] = '{r:8'd0,   g:8'd0,   b:8'd255, h:9'd240, s:8'd255, v:8'd255, lat_fast:34};
        tbl[3] = '{r:8'd255, g:8'd0,   b:8'd128, h:9'd330, s:8'd255, v:8'd255, lat_fast:34};
        tbl[4] = '{r:8'd255, g:8'd0,   b:8'd1,   h:9'd0,   s:8'd255, v:8'd255, lat_fast:34};
        tbl[5] = '{r:8'd200, g:8'd200, b:8'd50,  h:9'd60,  s:8'd191, v:8'd200, lat_fast:34};
        tbl[6] = '{r:8'd128, g:8'd128, b:8'd128, h:9'd0,   s:8'd0,   v:8'd128, lat_fast:2};
        tbl[7] = '{r:8'd0,   g:8'd0,   b:8'd0,   h:9'd0,   s:8'd0,   v:8'd0,   lat_fast:2};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; use_slow = 1'b0;
        red = 8'd0; green = 8'd0; blue = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset fast outputs", {f_out_valid, f_hue, f_sat, f_val}, 32'd0);
        check_output("reset slow outputs", {s_out_valid, s_hue, s_sat, s_val}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post-reset fast ready/busy", {30'd0, f_in_ready, f_busy}, 32'd2);
        check_output("post-reset slow ready/busy", {30'd0, s_in_ready, s_busy}, 32'd2);

        // The table vectors run on both instances. Only the fast-path instance shortens gray pixels.
        for (int pass = 0; pass < 2; pass++) begin
            use_slow = (pass == 1);
            for (int i = 0; i < 8; i++) begin
                e.h = tbl[i].h; e.s = tbl[i].s; e.v = tbl[i].v;
                lat = use_slow ? 34 : tbl[i].lat_fast;
                apply_stimulus(tbl[i].r, tbl[i].g, tbl[i].b, e, lat,
                               $sformatf("vec%0d_%s", i, use_slow ? "slow" : "fast"));
            end
        end

        // Random pixels, with every fourth one forced gray.
        for (int pass = 0; pass < 2; pass++) begin
            use_slow = (pass == 1);
            for (int i = 0; i < 12; i++) begin
                r = 8'($urandom_range(0, 255));
                g = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                if (i % 4 == 0) begin
                    g = r; b = r;
                end
                e = model(r, g, b);
                lat = (!use_slow && r == g && g == b) ? 2 : 34;
                apply_stimulus(r, g, b, e, lat, $sformatf("rand%0d_%s", i, use_slow ? "slow" : "fast"));
            end
        end

        // Back-pressure: hold the result for 10 cycles while another pixel is offered and must be refused.
        use_slow = 1'b0;
        out_ready = 1'b0;
        wait_idle();
        red = 8'd255; green = 8'd0; blue = 8'd128; in_valid = 1'b1;
        exp_q.push_back('{h:9'd330, s:8'd255, v:8'd255});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat <= 100) begin
            @(negedge clk);
            if (m_out_valid === 1'b1) break;
            lat++;
        end
        check_output("backpressure latency", 32'(lat), 32'd34);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            red = 8'd0; green = 8'd255; blue = 8'd0; in_valid = 1'b1;
            @(negedge clk);
            check_output($sformatf("backpressure hold%0d", i),
                         {m_out_valid, m_in_ready, m_hue, m_sat, m_val},
                         {1'b1, 1'b0, 9'd330, 8'd255, 8'd255});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("backpressure handoff", {30'd0, m_out_valid, m_in_ready}, 32'd1);
        check_output("backpressure queue drained", 32'(exp_q.size()), 32'd0);

        // Reset during the hue division drops the pixel, and no result may appear afterwards.
        red = 8'd0; green = 8'd255; blue = 8'd0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_output("busy in DIV_H", 32'(m_busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid-op reset outputs", {m_out_valid, m_hue, m_sat, m_val}, 32'd0);
        check_output("mid-op reset ready", 32'(m_in_ready), 32'd1);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_out_valid !== 1'b0) spurious++;
        end
        check_output("no spurious result", 32'(spurious), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
